truth_table_sweeper: RTL and testbench

- Sequential stimulus and checker stage for the combinational truth-table function blocks.
- Drives every input combination onto a function bank, waits a fixed settle time, then samples the bank's outputs.
- Compares each sampled row against a packed expected table and reports pass/fail, mismatch count and first-failure details.
- Replaces hand-written for-loop benches with a reusable clocked block.

---
 rtl/truth_table_sweeper.sv | 138 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Clocked stimulus/checker for a combinational truth-table bank: walks every input
// row, waits SETTLE cycles, samples the bank and scores it against a packed golden table.
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int N_FUNC = 5,
  parameter int SETTLE = 2,
  parameter logic [N_FUNC*(2**N_IN)-1:0] EXPECTED = 20'hB29DB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_FUNC-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_row,
  output logic [N_FUNC-1:0] fail_bits
);

  localparam int ROWS = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_ROW    = N_IN'(ROWS - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [N_IN-1:0]     r_row;
  logic [3:0]          r_settle;
  logic [N_IN:0]       r_err;
  logic                r_fail_valid;
  logic [N_IN-1:0]     r_fail_row;
  logic [N_FUNC-1:0]   r_fail_bits;
  logic                r_pass;
  logic [N_IN-1:0]     r_stim;
  logic                r_busy;
  logic                r_done;

  logic [N_FUNC-1:0]   w_exp;
  logic [N_FUNC-1:0]   w_diff;
  logic                w_mis;
  logic [N_IN-1:0]     w_stim;
  logic                w_busy;
  logic                w_done;

  assign w_exp  = EXPECTED[int'(r_row)*N_FUNC +: N_FUNC];
  assign w_diff = resp ^ w_exp;
  assign w_mis  = |w_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_settle == SETTLE_LAST) w_next = S_CHECK;
      S_CHECK:  w_next = (r_row == LAST_ROW) ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    w_stim = (r_state == S_IDLE) ? '0 : r_row;
    w_busy = (r_state == S_SETTLE) || (r_state == S_CHECK);
    w_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_row   <= '0;
      r_fail_bits  <= '0;
      r_pass       <= 1'b0;
      r_stim       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_stim <= w_stim;
      r_busy <= w_busy;
      r_done <= w_done;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row        <= '0;
            r_settle     <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_row   <= '0;
            r_fail_bits  <= '0;
            r_pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_settle != SETTLE_LAST) r_settle <= r_settle + 4'd1;
        end
        S_CHECK: begin
          if (w_mis) begin
            r_err <= r_err + 1'b1;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_row   <= r_row;
              r_fail_bits  <= w_diff;
            end
          end
          if (r_row != LAST_ROW) begin
            r_row    <= r_row + 1'b1;
            r_settle <= '0;
          end
        end
        S_DONE: begin
          r_pass <= (r_err == '0);
        end
        default: ;
      endcase
    end
  end

  assign stim       = r_stim;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_row   = r_fail_row;
  assign fail_bits  = r_fail_bits;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a behavioural function bank with fault modes drives two
// instances (default SETTLE and SETTLE=1); sweep results are scored through a queue.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st = 1'b0;
  int         sel = 0;
  int         mode = 0;
  logic       tog = 1'b0;

  logic       start0, start1;
  logic [1:0] stim0, stim1;
  logic [4:0] resp0, resp1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
  logic       fv0, fv1;
  logic [1:0] frow0, frow1;
  logic [4:0] fbits0, fbits1;

  logic [1:0] mon_stim;
  logic       mon_busy, mon_done, mon_pass, mon_fv;
  logic [2:0] mon_err;
  logic [1:0] mon_frow;
  logic [4:0] mon_fbits;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_row(frow0), .fail_bits(fbits0)
  );

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_row(frow1), .fail_bits(fbits1)
  );

  // Reference bank: a=~x&~y, b=1, c=y, d=~x|~y, e=~(x^y); x is the stim MSB.
  function automatic logic [4:0] golden(input logic [1:0] s);
    logic x, y;
    x = s[1];
    y = s[0];
    return {~(x ^ y), ~x | ~y, y, 1'b1, ~x & ~y};
  endfunction

  always_comb begin
    resp0 = golden(stim0);
    if (mode == 1) resp0 = golden(stim0) & 5'b11011;
    else if (mode == 2) resp0 = 5'b00000;
    resp1 = tog ? ~golden(stim1) : golden(stim1);
  end

  assign start0    = st && (sel == 0);
  assign start1    = st && (sel == 1);
  assign mon_stim  = (sel == 1) ? stim1  : stim0;
  assign mon_busy  = (sel == 1) ? busy1  : busy0;
  assign mon_done  = (sel == 1) ? done1  : done0;
  assign mon_pass  = (sel == 1) ? pass1  : pass0;
  assign mon_err   = (sel == 1) ? err1   : err0;
  assign mon_fv    = (sel == 1) ? fv1    : fv0;
  assign mon_frow  = (sel == 1) ? frow1  : frow0;
  assign mon_fbits = (sel == 1) ? fbits1 : fbits0;

  typedef struct {
    int         inst;
    int         mode;
    bit         again;
    int         err;
    bit         pass;
    bit         fv;
    int         row;
    logic [4:0] bits;
  } vec_t;

  typedef struct {
    int         err;
    bit         pass;
    bit         fv;
    int         row;
    logic [4:0] bits;
  } exp_t;

  vec_t tbl[5];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic run_sweep(input vec_t v);
    exp_t e;
    int   settle;
    int   done_k;
    settle = (v.inst == 1) ? 1 : 2;
    done_k = 4 * (settle + 1) + 1;
    sel  = v.inst;
    mode = v.mode;
    e.err = v.err; e.pass = v.pass; e.fv = v.fv; e.row = v.row; e.bits = v.bits;
    @(negedge clk);
    st = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    st  = 1'b0;
    tog = (v.mode == 3);
    for (int k = 1; k <= done_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      tog = (v.mode == 3) && (k % 2 == 0);
      if (v.again && k == 4) st = 1'b1;
      if (v.again && k == 5) st = 1'b0;
      chk($sformatf("done@k%0d", k), int'(mon_done), int'(k == done_k));
      chk($sformatf("busy@k%0d", k), int'(mon_busy), int'(k < done_k));
      if (k < done_k) chk($sformatf("stim@k%0d", k), int'(mon_stim), (k - 1) / (settle + 1));
    end
    tog = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("pass", int'(mon_pass), int'(e.pass));
      chk("err_count", int'(mon_err), e.err);
      chk("fail_valid", int'(mon_fv), int'(e.fv));
      if (e.fv) begin
        chk("fail_row", int'(mon_frow), e.row);
        chk("fail_bits", int'(mon_fbits), int'(e.bits));
      end
      repeat (2) @(negedge clk);
      chk("persist_pass", int'(mon_pass), int'(e.pass));
      chk("persist_err", int'(mon_err), e.err);
      chk("idle_stim", int'(mon_stim), 0);
      chk("idle_done", int'(mon_done), 0);
    end
  endtask

  initial begin
    tbl[0] = '{inst:0, mode:0, again:1'b0, err:0, pass:1'b1, fv:1'b0, row:0, bits:5'b00000};
    tbl[1] = '{inst:0, mode:1, again:1'b0, err:2, pass:1'b0, fv:1'b1, row:1, bits:5'b00100};
    tbl[2] = '{inst:0, mode:2, again:1'b0, err:4, pass:1'b0, fv:1'b1, row:0, bits:5'b11011};
    tbl[3] = '{inst:0, mode:0, again:1'b1, err:0, pass:1'b1, fv:1'b0, row:0, bits:5'b00000};
    tbl[4] = '{inst:1, mode:3, again:1'b0, err:0, pass:1'b1, fv:1'b0, row:0, bits:5'b00000};

    repeat (3) @(negedge clk);
    chk("rst_stim", int'(stim0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_fv", int'(fv0), 0);
    chk("rst_busy1", int'(busy1), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

    // Asynchronous reset in the middle of row 2, then a clean restart.
    sel  = 0;
    mode = 0;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_stim", int'(stim0), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_stim", int'(stim0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_pass", int'(pass0), 0);
    chk("abort_err", int'(err0), 0);
    chk("abort_fv", int'(fv0), 0);
    chk("abort_frow", int'(frow0), 0);
    chk("abort_fbits", int'(fbits0), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      chk($sformatf("abort_nodone%0d", k), int'(done0), 0);
    end
    run_sweep(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
